// File: rtl/cp0_tlb_seq.sv
// cp0_tlb_seq: multi-cycle sequencer for TLBP/TLBR/TLBWI/TLBWR with CP0 writeback and Random counter
module cp0_tlb_seq #(
  parameter int TLB_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 op_valid_i,
  input  logic [1:0]           op_i,
  input  logic                 flush_i,
  input  logic [31:0]          index_i,
  input  logic [31:0]          entryhi_i,
  input  logic [85:0]          entry_i,
  output logic                 tlb_re_o,
  output logic [TLB_WIDTH-1:0] tlb_raddr_o,
  input  logic [85:0]          tlb_rdata_i,
  output logic                 tlb_we_o,
  output logic [TLB_WIDTH-1:0] tlb_waddr_o,
  output logic [85:0]          tlb_wdata_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 wb_index_we_o,
  output logic [31:0]          wb_index_o,
  output logic                 wb_entry_we_o,
  output logic [31:0]          wb_entryhi_o,
  output logic [31:0]          wb_entrylo0_o,
  output logic [31:0]          wb_entrylo1_o,
  output logic [31:0]          random_o
);
  localparam logic [TLB_WIDTH:0] NK = {1'b1, {TLB_WIDTH{1'b0}}};
  typedef enum logic [2:0] {IDLE, PROBE, READ, WB, DONE} state_t;
  state_t               state;
  logic [1:0]           op;
  logic [TLB_WIDTH:0]   k;
  logic [TLB_WIDTH-1:0] rnd, raddr_q, waddr_q;
  logic [85:0]          wdata_q;
  logic                 accept, hit, live;
  assign accept = state == IDLE && op_valid_i && !flush_i && !rst;
  assign live = !flush_i && !rst;
  assign hit = tlb_rdata_i[70:52] == entryhi_i[31:13] &&
               (tlb_rdata_i[71] || tlb_rdata_i[79:72] == entryhi_i[7:0]);
  assign busy_o = state != IDLE;
  assign random_o = 32'(rnd);
  // Array-side signals are combinational so the access lands in the accept cycle;
  // the shadow registers keep the buses stable between accesses.
  always_comb begin
    tlb_re_o = (accept && !op_i[1]) || (state == PROBE && k < NK && !rst);
    tlb_raddr_o = !tlb_re_o ? raddr_q : accept ? (op_i[0] ? index_i[TLB_WIDTH-1:0] : '0) : k[TLB_WIDTH-1:0];
    tlb_we_o = accept && op_i[1];
    tlb_waddr_o = !tlb_we_o ? waddr_q : op_i[0] ? rnd : index_i[TLB_WIDTH-1:0];
    tlb_wdata_o = tlb_we_o ? entry_i : wdata_q;
    done_o = (state == WB || state == DONE) && live;
    wb_index_we_o = state == WB && op == 2'b00 && live;
    wb_entry_we_o = state == WB && op == 2'b01 && live;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op <= '0;
      k <= '0;
      rnd <= '1;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wb_index_o <= '0;
      wb_entryhi_o <= '0;
      wb_entrylo0_o <= '0;
      wb_entrylo1_o <= '0;
    end else begin
      rnd <= rnd - 1'b1;
      raddr_q <= tlb_raddr_o;
      waddr_q <= tlb_waddr_o;
      wdata_q <= tlb_wdata_o;
      if (state == IDLE) begin
        if (accept) begin
          op <= op_i;
          k <= 1;
          state <= op_i[1] ? DONE : op_i[0] ? READ : PROBE;
        end
      end else if (flush_i) begin
        state <= IDLE;
      end else if (state == PROBE) begin
        // rdata in probe step k is entry k-1, so a hit reports k-1
        if (hit || k == NK) begin
          wb_index_o <= hit ? 32'(k - 1'b1) : 32'h8000_0000;
          state <= WB;
        end else begin
          k <= k + 1'b1;
        end
      end else if (state == READ) begin
        wb_entryhi_o <= {tlb_rdata_i[70:52], 5'b0, tlb_rdata_i[79:72]};
        wb_entrylo0_o <= 32'({tlb_rdata_i[25:2], tlb_rdata_i[85:83], tlb_rdata_i[1:0], tlb_rdata_i[71]});
        wb_entrylo1_o <= 32'({tlb_rdata_i[51:28], tlb_rdata_i[82:80], tlb_rdata_i[27:26], tlb_rdata_i[71]});
        state <= WB;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: doc/cp0_tlb_seq.md
Name: cp0_tlb_seq

Overview:
- Multi-cycle sequencer for the CP0 TLB instructions TLBP, TLBR, TLBWI and TLBWR.
- Sits between the MEM-stage instruction decode, the CP0 register file (Index/EntryHi/EntryLo0/EntryLo1) and an external TLB entry array with a synchronous 1-cycle-latency read port.
- Stalls the pipeline while busy, scans the array for probes, and writes the results back into CP0.
- Maintains the CP0 Random counter used by TLBWR.

Parameters:
- TLB_WIDTH, 4, log2 of TLB entry count; N = 2**TLB_WIDTH entries.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- op_valid_i  in  1  TLB instruction request; sampled only in IDLE.
- op_i  in  2  00=TLBP, 01=TLBR, 10=TLBWI, 11=TLBWR.
- flush_i  in  1  pipeline flush; aborts the operation in progress.
- index_i  in  32  current CP0 Index.
- entryhi_i  in  32  current CP0 EntryHi (VPN2 [31:13], ASID [7:0]).
- entry_i  in  86  entry built from CP0 EntryHi/EntryLo0/EntryLo1. Format: C0[85:83], C1[82:80], ASID[79:72], G[71], VPN2[70:52], PFN1[51:28], D1V1[27:26], PFN0[25:2], D0V0[1:0].
- tlb_re_o  out  1  array read enable.
- tlb_raddr_o  out  TLB_WIDTH  array read address.
- tlb_rdata_i  in  86  array read data, valid the cycle after tlb_re_o; same format as entry_i.
- tlb_we_o  out  1  array write enable.
- tlb_waddr_o  out  TLB_WIDTH  array write address.
- tlb_wdata_o  out  86  array write data.
- busy_o  out  1  stall request to the pipeline.
- done_o  out  1  one-cycle completion pulse.
- wb_index_we_o  out  1  CP0 Index write strobe.
- wb_index_o  out  32  Index write value.
- wb_entry_we_o  out  1  strobe for CP0 EntryHi/EntryLo0/EntryLo1 write.
- wb_entryhi_o  out  32  EntryHi write value.
- wb_entrylo0_o  out  32  EntryLo0 write value.
- wb_entrylo1_o  out  32  EntryLo1 write value.
- random_o  out  32  CP0 Random value, zero-extended.

Behaviour:
- Reset: state IDLE. All strobes (tlb_re_o, tlb_we_o, busy_o, done_o, wb_*_we_o) are 0. All data outputs are 0, except random_o = N-1.
- Random:
  - Decrements every cycle.
  - Wraps from 0 to N-1.
  - Continues counting while busy.
  - Unaffected by flush_i.
- States: IDLE, PROBE, READ, WB, DONE. busy_o = (state != IDLE); it is registered.
- Accept: in IDLE with op_valid_i=1 and flush_i=0. Cycle 0 is the accept cycle. In IDLE with flush_i=1, the request is dropped.
- TLBP:
  - Cycle 0: tlb_re_o=1, raddr=0; go to PROBE with counter k=1.
  - In PROBE, cycle k: tlb_rdata_i holds entry k-1. If k<N, also issue raddr=k.
  - Match rule: rdata VPN2 == entryhi_i[31:13] AND (rdata G OR rdata ASID == entryhi_i[7:0]).
  - First match wins (lowest index). On match, latch the index and go to WB.
  - At k==N with no match: latch a miss and go to WB.
  - WB cycle: wb_index_we_o=1 and done_o=1.
    - Hit at j: wb_index_o = {1'b0, zeros, j}; done_o fires in cycle j+2.
    - Miss: wb_index_o = 32'h80000000; done_o fires in cycle N+1.
  - Then go to IDLE.
- TLBR:
  - Cycle 0: re=1, raddr=index_i[TLB_WIDTH-1:0]; go to READ.
  - Cycle 1: latch rdata; go to WB.
  - Cycle 2: wb_entry_we_o=1, done_o=1, with:
    - wb_entryhi_o = {VPN2, 5'b0, ASID}
    - wb_entrylo0_o = {6'b0, PFN0, C0, D0, V0, G}
    - wb_entrylo1_o = {6'b0, PFN1, C1, D1, V1, G}
  - wb_index_we_o stays 0.
- TLBWI / TLBWR:
  - Cycle 0: tlb_we_o=1, tlb_wdata_o=entry_i. tlb_waddr_o = index_i[TLB_WIDTH-1:0] for TLBWI, or the current random value for TLBWR.
  - Cycle 1: state DONE, done_o=1, no CP0 writeback.
- Strobes: all are single-cycle and valid only in the stated cycles. Data outputs hold their last values otherwise.
- Flush:
  - flush_i in PROBE, READ, WB or DONE returns to IDLE next cycle.
  - In that same cycle, wb_*_we_o and done_o are suppressed.
  - A write issued in cycle 0 is never retracted.
- Reset mid-operation: immediate return to reset values; no writeback.
- op_valid_i while busy: ignored. The pipeline holds the request until it sees done_o.

Test Plan:
- TLBP hit: N=16, entry 5 has VPN2=0x12345, ASID=0x07, G=0; entryhi_i={0x12345, 5'b0, 0x07}. Required: done_o and wb_index_we_o in cycle 7, wb_index_o=5, busy_o high in cycles 1-7.
- TLBP global/dup/miss:
  - Entries 3 and 9 match via G=1 with ASID mismatch → index 3 reported.
  - No match → wb_index_o=0x80000000, done_o in cycle 17.
- TLBR: index_i=2, entry 2 = {C0=3, C1=2, ASID=0x11, G=1, VPN2=0x00ABC, PFN1=0x1, D1V1=11, PFN0=0x2, D0V0=01}. Required: cycle 2 gives wb_entryhi_o=0x0157_8011, wb_entrylo0_o=0x0000_009B, wb_entrylo1_o=0x0000_0057.
- TLBWI/TLBWR:
  - TLBWI with index_i=4 → tlb_we_o in cycle 0 with waddr=4; done_o in cycle 1.
  - TLBWR issued when random_o=9 → waddr=9.
  - random_o runs N-1 → 0 → N-1 across 16 cycles after reset.
- Flush/reset: flush_i during PROBE cycle 3 → IDLE in cycle 4, no done_o, no wb strobes. rst asserted in READ → all outputs at reset values the next cycle. op_valid_i together with flush_i in IDLE → not accepted.
